bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-port arbiter and sequencer for the single shared memory bus in the RV32I core. It sits between the instruction-fetch requester and the load/store (data) requester on one side and the bus manager on the other. It grants one requester at a time, drives one bus transaction, and waits for completion or timeout. It then returns read data and a one-cycle done pulse to the winning requester. Contention between the two requesters is resolved round-robin.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, cycles in ISSUE+WAIT_ACK before the transaction is aborted with error (counter width = $clog2(TIMEOUT+1))
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- i_req  in  1  instruction fetch request (read only)
- i_addr  in  ADDR_W  fetch address
- i_data  out  DATA_W  fetched instruction, valid while i_done=1
- i_done  out  1  one-cycle completion pulse, fetch port
- i_err  out  1  asserted with i_done when the fetch timed out
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_sel  in  4  byte enables
- d_rdata  out  DATA_W  load data, valid while d_done=1
- d_done  out  1  one-cycle completion pulse, data port
- d_err  out  1  asserted with d_done when the data access timed out
- bus_addr  out  ADDR_W  latched transaction address
- bus_wdata  out  DATA_W  latched store data
- bus_sel  out  4  latched byte enables
- bus_read  out  1  read command, high only in ISSUE
- bus_write  out  1  write command, high only in ISSUE
- bus_busy  in  1  bus cannot accept a command this cycle
- bus_ack  in  1  transaction complete; bus_rdata valid this cycle
- bus_rdata  in  DATA_W  read data from bus

## Operation
- States: IDLE, ISSUE, WAIT_ACK, RESP. Reset gives state=IDLE, last_grant=I, timeout counter=0, and every output 0.
- IDLE, grant selection:
  - Only i_req high: grant I.
  - Only d_req high: grant D.
  - Both high: grant the port opposite to last_grant.
  - No request: stay in IDLE.
- IDLE, on grant:
  - Latch addr, wdata, sel and we into the bus_* registers.
  - A fetch latches sel=4'hF, we=0 and wdata=0.
  - Update last_grant, clear the counter, and go to ISSUE.
- ISSUE:
  - bus_read = ~we and bus_write = we.
  - The command is accepted in a cycle where bus_busy=0; go to WAIT_ACK.
  - If bus_busy=1, hold the command and increment the counter.
- WAIT_ACK:
  - Commands are low.
  - On bus_ack=1, capture bus_rdata (loads and fetches), or capture 0 for stores, then go to RESP with err=0.
  - Otherwise increment the counter.
- Timeout: in ISSUE or WAIT_ACK, if the counter equals TIMEOUT, go to RESP with err=1, captured data=0 and commands dropped. Timeout takes priority over a same-cycle bus_ack.
- RESP:
  - Pulse done for the granted port only, with registered data and err on that port.
  - The other port's done, err and data stay 0. Data and err outputs are 0 outside RESP.
  - Go to IDLE.
- Requests are sampled only in IDLE. Operands must be stable in the IDLE cycle in which the grant occurs. req must be held until done. A req still high in the IDLE cycle after RESP starts a new transaction.
- bus_ack outside WAIT_ACK is ignored. A bus_busy change outside ISSUE is ignored.
- rst in any state aborts the transaction on the next edge: no done pulse, commands low, all outputs 0.

## Timing
- Minimum latency:
  - Request sampled in IDLE at cycle 0.
  - bus_read or bus_write high at cycle 1 (ISSUE).
  - With bus_busy=0 at cycle 1 and bus_ack at cycle 2, done is at cycle 3.
- Each bus_busy cycle in ISSUE and each cycle without ack in WAIT_ACK adds one cycle.
- Maximum latency: 2 + TIMEOUT + 1 cycles, ending in done with err=1.
- Throughput: back-to-back transactions from one port have a 4-cycle minimum period (IDLE, ISSUE, WAIT_ACK, RESP).
- Under continuous contention, grants strictly alternate D, I, D, I…; the first contention after reset goes to D. Neither port waits more than one transaction.
- The bus_* address, data and sel registers hold their value until the next grant.

## Test plan
- Single fetch: i_req=1, i_addr=0x0000_0100; bus_ack at cycle 2 with bus_rdata=0x0000_0513 → bus_read=1 in cycle 1 only, bus_addr=0x100, i_done=1 with i_data=0x0000_0513 at cycle 3, i_err=0, d_done=0.
- Store with bus stall: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_sel=0x3; bus_busy=1 for 3 cycles, then ack → bus_write high for 4 cycles (cycles 1–4), bus_sel=0x3, bus_wdata=0xDEADBEEF, d_done at cycle 6 with d_rdata=0.
- Contention: i_req and d_req both held, each dropped on its done; bus acks immediately → grant order D, I, D, I; each done arrives 4 cycles after the previous one.
- Timeout: TIMEOUT=8, load with no bus_ack → d_done=1 and d_err=1 exactly 2+8+1=11 cycles after the request; d_rdata=0; a following fetch completes normally.
- Reset mid-transaction: rst=1 during WAIT_ACK → state IDLE, all outputs 0, no done pulse; a late bus_ack after rst deasserts is ignored.
- Same-cycle ack and timeout: bus_ack asserted in the cycle the counter reaches TIMEOUT → done with err=1 and data=0.

Source files
------------

// File: rtl/bus_arbiter.sv
// Round-robin arbiter between the fetch and load/store ports of the RV32I core,
// sequencing one shared-bus transaction at a time with a completion timeout.
module bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_data,
    output logic              i_done,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_sel,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_err,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [3:0]        bus_sel,
    output logic              bus_read,
    output logic              bus_write,
    input  logic              bus_busy,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, RESP} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_gnt_d, w_gnt_d_nxt;   // current grant in flight, last grant while IDLE
    logic              r_we, w_we_nxt;
    logic              r_err, w_err_nxt;
    logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic [3:0]        r_sel, w_sel_nxt;
    logic              w_timeout;
    logic              w_cmd;
    logic              w_resp;

    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gnt_d_nxt = r_gnt_d;
        w_we_nxt    = r_we;
        w_err_nxt   = r_err;
        w_rdata_nxt = r_rdata;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_sel_nxt   = r_sel;

        unique case (r_state)
            IDLE: begin
                if (i_req || d_req) begin
                    // Under contention the port that did not win last time goes next.
                    w_gnt_d_nxt = d_req && (!i_req || !r_gnt_d);
                    w_cnt_nxt   = '0;
                    w_state_nxt = ISSUE;
                    if (w_gnt_d_nxt) begin
                        w_addr_nxt  = d_addr;
                        w_wdata_nxt = d_wdata;
                        w_sel_nxt   = d_sel;
                        w_we_nxt    = d_we;
                    end else begin
                        w_addr_nxt  = i_addr;
                        w_wdata_nxt = '0;
                        w_sel_nxt   = 4'hF;
                        w_we_nxt    = 1'b0;
                    end
                end
            end
            ISSUE: begin
                if (w_timeout) begin
                    w_state_nxt = RESP;
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = '0;
                end else if (!bus_busy) begin
                    w_state_nxt = WAIT_ACK;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            WAIT_ACK: begin
                // Timeout wins over an ack arriving in the same cycle.
                if (w_timeout) begin
                    w_state_nxt = RESP;
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = '0;
                end else if (bus_ack) begin
                    w_state_nxt = RESP;
                    w_err_nxt   = 1'b0;
                    w_rdata_nxt = r_we ? '0 : bus_rdata;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the latched bus fields are reset too, so every output reads 0 after reset.
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_gnt_d <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_sel   <= '0;
        end else begin
            // NOTE: non-blocking so all registers update from the same pre-edge values.
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt_d <= w_gnt_d_nxt;
            r_we    <= w_we_nxt;
            r_err   <= w_err_nxt;
            r_rdata <= w_rdata_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    // The command is withdrawn in the cycle the timeout fires.
    assign w_cmd     = (r_state == ISSUE) && !w_timeout;
    assign w_resp    = (r_state == RESP);
    assign bus_read  = w_cmd && !r_we;
    assign bus_write = w_cmd && r_we;
    assign bus_addr  = r_addr;
    assign bus_wdata = r_wdata;
    assign bus_sel   = r_sel;

    assign i_done  = w_resp && !r_gnt_d;
    assign d_done  = w_resp && r_gnt_d;
    assign i_err   = i_done && r_err;
    assign d_err   = d_done && r_err;
    assign i_data  = i_done ? r_rdata : '0;
    assign d_rdata = d_done ? r_rdata : '0;
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized transactions
// checked against a cycle-count latency model of the arbiter.
module tb_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int NEVER = 100000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_req = 1'b0;
    logic [AW-1:0] i_addr = '0;
    logic [DW-1:0] i_data;
    logic          i_done, i_err;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [3:0]    d_sel = '0;
    logic [DW-1:0] d_rdata;
    logic          d_done, d_err;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [3:0]    bus_sel;
    logic          bus_read, bus_write;
    logic          bus_busy = 1'b0;
    logic          bus_ack = 1'b0;
    logic [DW-1:0] bus_rdata = '0;

    int   n_checks = 0;
    int   n_fails  = 0;
    logic model_last_d = 1'b0;

    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_data(i_data), .i_done(i_done), .i_err(i_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_sel(d_sel),
        .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_sel(bus_sel),
        .bus_read(bus_read), .bus_write(bus_write),
        .bus_busy(bus_busy), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One transaction on a single port. b = busy cycles in ISSUE, a = cycles without ack in
    // WAIT_ACK. Expected latency comes from the counter rules: the counter grows by one per
    // busy or ack-less cycle and aborts the transfer when it reaches TO.
    task automatic run_txn(input string name, input logic port_d, input logic we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [3:0] sel, input logic [DW-1:0] rdata,
                           input int b, input int a, input bit noise);
        int            lat, cmd_last, ack_cyc;
        logic          exp_err, exp_we, done_now, cmd_now;
        logic [DW-1:0] exp_data, exp_wdata;
        logic [3:0]    exp_sel;
        logic [5:0]    f_obs, f_exp;
        logic [63:0]   dat_obs, dat_exp;
        logic [67:0]   reg_obs, reg_exp;
        if (b >= TO) begin
            lat = TO + 2; exp_err = 1'b1; cmd_last = TO;
        end else if (b + a >= TO) begin
            lat = TO + 3; exp_err = 1'b1; cmd_last = b + 1;
        end else begin
            lat = b + a + 3; exp_err = 1'b0; cmd_last = b + 1;
        end
        ack_cyc   = b + 2 + a;
        exp_we    = port_d & we;
        exp_wdata = port_d ? wdata : '0;
        exp_sel   = port_d ? sel : 4'hF;
        exp_data  = (exp_err || exp_we) ? '0 : rdata;

        @(negedge clk);
        if (port_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_sel = sel;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        bus_busy = 1'b0;
        bus_ack  = 1'b0;
        for (int c = 1; c <= lat + 1; c++) begin
            @(negedge clk);
            done_now = (c == lat);
            cmd_now  = (c <= cmd_last);
            f_obs = {bus_read, bus_write, i_done, i_err, d_done, d_err};
            f_exp = {cmd_now && !exp_we, cmd_now && exp_we,
                     done_now && !port_d, done_now && !port_d && exp_err,
                     done_now && port_d, done_now && port_d && exp_err};
            n_checks++;
            if (f_obs !== f_exp) begin
                n_fails++;
                $display("FAIL %s ctrl c=%0d {rd,wr,idone,ierr,ddone,derr} got %b want %b",
                         name, c, f_obs, f_exp);
            end
            dat_obs = {i_data, d_rdata};
            dat_exp = {(done_now && !port_d) ? exp_data : 32'h0,
                       (done_now && port_d) ? exp_data : 32'h0};
            n_checks++;
            if (dat_obs !== dat_exp) begin
                n_fails++;
                $display("FAIL %s data c=%0d {i_data,d_rdata} got %h want %h",
                         name, c, dat_obs, dat_exp);
            end
            reg_obs = {bus_addr, bus_wdata, bus_sel};
            reg_exp = {addr, exp_wdata, exp_sel};
            n_checks++;
            if (reg_obs !== reg_exp) begin
                n_fails++;
                $display("FAIL %s busregs c=%0d {addr,wdata,sel} got %h want %h",
                         name, c, reg_obs, reg_exp);
            end
            if (done_now) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
            if (noise) begin
                d_addr = $urandom; d_wdata = $urandom; d_sel = 4'($urandom); i_addr = $urandom;
            end
            bus_busy  = (c <= b) ? 1'b1 :
                        ((noise && c > b + 1 && c < lat) ? 1'($urandom_range(0, 1)) : 1'b0);
            bus_ack   = (c == ack_cyc) ? 1'b1 :
                        ((noise && c <= b + 1) ? 1'($urandom_range(0, 1)) : 1'b0);
            bus_rdata = (c == ack_cyc) ? rdata : $urandom;
        end
        bus_busy = 1'b0;
        bus_ack  = 1'b0;
        model_last_d = port_d;
    endtask

    task automatic expect_all_zero(input string name);
        logic [139:0] obs;
        obs = {bus_read, bus_write, i_done, i_err, d_done, d_err,
               bus_addr, bus_wdata, bus_sel, i_data, d_rdata};
        n_checks++;
        if (obs !== '0) begin
            n_fails++;
            $display("FAIL %s all outputs got %h want 0", name, obs);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        expect_all_zero("reset_held");
        rst = 1'b0;
        @(negedge clk);
        expect_all_zero("reset_released");
        model_last_d = 1'b0;
    endtask

    task automatic test_single_fetch();
        run_txn("single_fetch", 1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'h0000_0513, 0, 0, 1'b0);
    endtask

    task automatic test_store_stall();
        run_txn("store_stall", 1'b1, 1'b1, 32'h0000_2000, 32'hDEADBEEF, 4'h3, 32'h1234_5678, 3, 0, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn("timeout_load", 1'b1, 1'b0, 32'h0000_3000, 32'h0, 4'hF, 32'hCAFE_F00D, 0, NEVER, 1'b0);
        run_txn("after_timeout_fetch", 1'b0, 1'b0, 32'h0000_0104, 32'h0, 4'h0, 32'h0010_0093, 0, 0, 1'b0);
        run_txn("busy_timeout", 1'b0, 1'b0, 32'h0000_0108, 32'h0, 4'h0, 32'h1111_2222, TO, 0, 1'b0);
        run_txn("busy_below_timeout", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 32'h3333_4444, TO - 1, 0, 1'b0);
    endtask

    task automatic test_ack_timeout_same_cycle();
        run_txn("ack_at_timeout", 1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'hF, 32'h5555_6666, 2, TO - 2, 1'b0);
        run_txn("ack_before_timeout", 1'b1, 1'b0, 32'h0000_4004, 32'h0, 4'hF, 32'h7777_8888, 2, TO - 3, 1'b0);
    endtask

    // Both ports request continuously from reset; grants alternate starting with D.
    task automatic test_contention();
        logic [DW-1:0] rd[4];
        logic          first_d, win_d, done_now;
        int            k;
        logic [5:0]    f_obs, f_exp;
        logic [63:0]   dat_obs, dat_exp;
        for (int i = 0; i < 4; i++) rd[i] = $urandom;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_last_d = 1'b0;
        first_d = ~model_last_d;
        i_req = 1'b1; i_addr = 32'h0000_0200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_5000; d_sel = 4'hF;
        win_d = first_d;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            k = c / 4;
            win_d = (k % 2 == 0) ? first_d : ~first_d;
            done_now = (c % 4 == 3);
            f_obs = {bus_read, bus_write, i_done, d_done};
            f_exp = {c % 4 == 1 && c < 16, 1'b0, done_now && !win_d, done_now && win_d};
            n_checks++;
            if ({f_obs[5:2]} !== {f_exp[5:2]}) begin
                n_fails++;
                $display("FAIL contention ctrl c=%0d {rd,wr,idone,ddone} got %b want %b",
                         c, f_obs[5:2], f_exp[5:2]);
            end
            dat_obs = {i_data, d_rdata};
            dat_exp = {(done_now && !win_d) ? rd[k] : 32'h0, (done_now && win_d) ? rd[k] : 32'h0};
            n_checks++;
            if (dat_obs !== dat_exp) begin
                n_fails++;
                $display("FAIL contention data c=%0d got %h want %h", c, dat_obs, dat_exp);
            end
            if (c % 4 == 1 && c < 16) begin
                n_checks++;
                if (bus_addr !== (win_d ? d_addr : i_addr)) begin
                    n_fails++;
                    $display("FAIL contention addr c=%0d got %h want %h",
                             c, bus_addr, win_d ? d_addr : i_addr);
                end
            end
            if (c == 15) begin
                i_req = 1'b0;
                d_req = 1'b0;
                model_last_d = win_d;
            end
            bus_ack   = (c % 4 == 2);
            bus_rdata = (c < 16) ? rd[k] : 32'h0;
        end
        bus_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_6000; d_sel = 4'hF;
        bus_busy = 1'b0; bus_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        d_req = 1'b0;
        @(negedge clk);
        expect_all_zero("reset_mid_wait");
        rst = 1'b0;
        @(negedge clk);
        expect_all_zero("reset_mid_released");
        bus_ack = 1'b1;
        bus_rdata = 32'hBAD0_BAD0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            bus_ack = 1'b0;
            expect_all_zero("late_ack_ignored");
        end
        model_last_d = 1'b0;
    endtask

    task automatic test_random();
        int b, a;
        for (int n = 0; n < 40; n++) begin
            b = $urandom_range(0, 3);
            a = $urandom_range(0, 4);
            if ($urandom_range(0, 7) == 0) b = $urandom_range(TO - 1, TO + 1);
            if ($urandom_range(0, 7) == 0) a = $urandom_range(TO - 2, TO + 3);
            run_txn("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    $urandom, $urandom, 4'($urandom), $urandom, b, a, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store_stall();
        test_timeout();
        test_ack_timeout_same_cycle();
        test_contention();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
